// File: rtl/px_adc_pkg.sv
// Shared types and constants for the pixel-ADC responder.
// The FSM state encoding and frame-length helper live here.
package px_adc_pkg;

  localparam int DEF_DATA_BITS  = 12;
  localparam int DEF_LEAD_ZEROS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    TAIL  = 2'd2
  } state_t;

  function automatic int frame_bits(input int lead_zeros, input int data_bits);
    return lead_zeros + data_bits;
  endfunction

endpackage

// File: rtl/px_adc_edge_sync.sv
// Brings an asynchronous pin into the clk domain and flags its edges.
// Rise/fall are single-cycle pulses derived from the synchronized level.
module px_adc_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // The chain carries no reset so a pin held low through reset does not
  // later look like a fresh edge.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    prev_q <= sync_q[SYNC_STAGES-1];
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/px_adc_responder.sv
// Serial pixel-ADC stand-in: answers cs/sclk from the capture master with
// frames of leading zeros followed by a sample taken from a valid/ready source.
module px_adc_responder
  import px_adc_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int LEAD_ZEROS  = DEF_LEAD_ZEROS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 adc_cs,
  input  logic                 adc_sclk,
  output logic                 adc_dout,
  output logic                 adc_dout_oe,
  input  logic [DATA_BITS-1:0] sample_data,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 frame_done,
  output logic                 underrun,
  output logic                 abort,
  output logic [15:0]          frame_count
);

  localparam int FRAME_BITS = frame_bits(LEAD_ZEROS, DATA_BITS);
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic                  cs_rise;
  logic                  cs_fall;
  logic                  sclk_rise;
  logic                  sclk_fall;
  state_t                state;
  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0]  last_sample;
  logic [DATA_BITS-1:0]  next_sample;
  logic [FRAME_BITS-1:0] frame_word;

  px_adc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk  (clk),
    .din  (adc_cs),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  px_adc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .din  (adc_sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  // Under-run replays the last delivered sample rather than sending garbage.
  assign next_sample  = sample_valid ? sample_data : last_sample;
  assign frame_word   = FRAME_BITS'(next_sample);
  assign sample_ready = (state == IDLE) && cs_fall && sample_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      last_sample <= '0;
      adc_dout    <= 1'b0;
      adc_dout_oe <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
      abort       <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      abort      <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            shreg       <= frame_word;
            adc_dout    <= frame_word[FRAME_BITS-1];
            adc_dout_oe <= 1'b1;
            bit_cnt     <= '0;
            state       <= SHIFT;
            if (sample_valid) last_sample <= sample_data;
            else              underrun    <= 1'b1;
          end
        end
        SHIFT: begin
          // A cs rise outranks a coincident sclk fall, even on the last bit.
          if (cs_rise) begin
            abort       <= 1'b1;
            adc_dout_oe <= 1'b0;
            adc_dout    <= 1'b0;
            state       <= IDLE;
          end else if (sclk_fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              adc_dout_oe <= 1'b0;
              adc_dout    <= 1'b0;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              state       <= TAIL;
            end else begin
              shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
              adc_dout <= shreg[FRAME_BITS-2];
            end
          end
        end
        TAIL: begin
          if (cs_rise) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_sclk_rise;
  assign unused_sclk_rise = sclk_rise;

endmodule

// File: doc/px_adc_responder.md
Name: px_adc_responder

Overview:
- Synthesizable stand-in for the serial pixel ADC on the cam0/cam1 px_adc_cs / px_adc_sclk / px_adc_din path.
- Listens to the ADC chip-select and serial clock driven by the camera capture master, oversampled on the system clock, and shifts out 16-bit frames: leading zeros followed by a 12-bit sample.
- Sample values come from a valid/ready source (pattern generator or fabric loopback).
- Used for on-board self-test and loopback of the capture path without a physical ADC.

Parameters:
- DATA_BITS, 12, sample width.
- LEAD_ZEROS, 4, zero bits sent before the sample MSB.
- SYNC_STAGES, 2, synchronizer depth on adc_cs and adc_sclk (minimum 2).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- adc_cs  in  1  chip-select from the capture master, active low, asynchronous to clk.
- adc_sclk  in  1  serial clock from the capture master, asynchronous to clk.
- adc_dout  out  1  serial data to the master's px_adc_din.
- adc_dout_oe  out  1  output enable; the top level tri-states the pad when 0.
- sample_data  in  DATA_BITS  next sample to send.
- sample_valid  in  1  sample_data is valid.
- sample_ready  out  1  one-cycle pulse; a sample is consumed on the cycle where sample_valid=1 and sample_ready=1.
- frame_done  out  1  one-cycle pulse when a full frame completes.
- underrun  out  1  one-cycle pulse when a frame starts with no valid sample.
- abort  out  1  one-cycle pulse when cs deasserts mid-frame.
- frame_count  out  16  completed-frame counter; wraps 0xFFFF to 0.

Behaviour:
- Synchronization: adc_cs and adc_sclk each pass through SYNC_STAGES flops, then a 1-flop edge detect.
  - Pin edge to adc_dout update: SYNC_STAGES+1 clk cycles.
  - Master constraint: sclk high and low phases each ≥ SYNC_STAGES+2 clk cycles; cs-fall to first sclk fall likewise.
- Constants: FRAME_BITS = LEAD_ZEROS + DATA_BITS (16).
- Reset values:
  - Outputs: adc_dout=0, adc_dout_oe=0, every pulse output 0, frame_count=0.
  - Internal: last_sample=0, shift register=0, bit_cnt=0, state=IDLE.
  - Reset mid-frame abandons the frame immediately, with no abort pulse.
- State IDLE (oe=0):
  - On sync'd cs fall: load shreg = {LEAD_ZEROS'b0, S}.
  - If sample_valid=1: S=sample_data, sample_ready pulses this cycle, last_sample<=sample_data.
  - If sample_valid=0: S=last_sample and underrun pulses.
  - In both cases: oe<=1, adc_dout<=shreg MSB (bit 0 of the frame), bit_cnt<=0, go to SHIFT.
  - sclk edges in IDLE are ignored.
  - sample_ready is 0 at all other times.
- State SHIFT (oe=1):
  - On each sync'd sclk falling edge: bit_cnt++ and the shift register moves left one place, so adc_dout presents frame bit bit_cnt+1.
  - On the FRAME_BITS-th falling edge: oe<=0, adc_dout<=0, frame_done pulses, frame_count++, go to TAIL.
  - sclk rising edges are ignored (the master samples on rising).
- State TAIL (oe=0):
  - Wait for sync'd cs rise, then go to IDLE.
  - Extra sclk edges are ignored; adc_dout stays 0.
- Mid-frame cs rise in SHIFT: abort pulses, oe<=0, adc_dout<=0, go to IDLE. frame_count is unchanged and the consumed sample is not re-queued.
- Simultaneous events:
  - cs rise and sclk fall detected in the same cycle in SHIFT: cs wins, so abort is reported even if it was the final edge.
  - cs fall detected while still in TAIL (rise missed): cannot occur with sync'd edges. TAIL exits only on a rise.
- Back-to-back frames: a cs rise, then a fall ≥ SYNC_STAGES+2 cycles later, starts a new frame normally.

Decomposition:
- Package px_adc_pkg:
  - state enum {IDLE, SHIFT, TAIL};
  - FRAME_BITS function;
  - default constants DATA_BITS=12, LEAD_ZEROS=4.
- Sub-module px_adc_edge_sync (SYNC_STAGES flop chain plus rise/fall pulse outputs), instantiated twice: for cs and for sclk.
- The FSM, shift register, counters and handshake stay in px_adc_responder.

Test Plan:
- Frame with data present: sample_valid=1, sample_data=0xA5C, full 16-sclk frame (sclk period 20 clk) → master reads 0x0A5C. Exactly one sample_ready pulse, one frame_done pulse, frame_count=1, oe low after the 16th fall.
- Underrun: first frame sends 0x123, then sample_valid=0 and a second frame runs → second frame reads 0x0123, underrun pulses once, frame_count=2.
- Abort: cs rises after 7 sclk falls → abort pulses, oe=0 within SYNC_STAGES+2 cycles, frame_count unchanged. The next frame with valid 0x001 reads 0x0001.
- Simultaneous: cs rise coincides with the 16th sclk fall at the synchronizer output → abort=1, frame_done=0.
- Wrap and reset: preload via 65535 frames (or force) → the next frame makes frame_count 0x0000. Assert reset during frame bit 9 → all outputs at reset values next cycle, no abort pulse, and a following frame with sample_data=0xFFF reads 0x0FFF.
- Extra clocks: 20 sclk pulses in one cs window → only 16 bits driven, bits 17–20 read 0 with oe=0, single frame_done.
